seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 Parameter CLK_DIV, default 50000, clk cycles per digit slot (>=2).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 value  input  4*DIGITS  hex nibbles; value[3:0] is digit 0, the least significant.
REQ-006 dp_in  input  DIGITS  decimal point per digit, 1 = lit.
REQ-007 load  input  1  one-cycle strobe; captures value/dp_in.
REQ-008 blank_en  input  1  leading-zero blanking request.
REQ-009 seg_out  output  7  segments {a,b,c,d,e,f,g} (bit6 = a), active-low, registered.
REQ-010 dp_out  output  1  decimal point, active-low, registered.
REQ-011 dig_sel  output  DIGITS  one-hot-low digit enable, registered.
REQ-012 frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-013 Prescaler SHALL count 0..CLK_DIV-1 and SHALL assert tick in the cycle it equals CLK_DIV-1, then return to 0.
REQ-014 On tick, digit index SHALL advance by 1 and wrap from DIGITS-1 to 0 (wrap tick).
REQ-015 Outputs SHALL reflect the current index with exactly one cycle of latency; dig_sel SHALL have exactly one bit low outside reset.
REQ-016 Decode (active-low, abcdefg): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-017 load SHALL copy value/dp_in into a pending register and set pending flag; a later load before transfer SHALL overwrite pending.
REQ-018 On wrap tick with pending set, pending SHALL transfer to the active register and pending flag SHALL clear; displayed data SHALL change only at frame boundaries (no tearing).
REQ-019 load coincident with wrap tick SHALL load value/dp_in directly into active and leave pending flag clear.
REQ-020 frame_done SHALL pulse high for one cycle, registered, in the cycle after each wrap tick.
REQ-021 Digit 0 SHALL never be blanked; dp_out SHALL follow dp_in of the active digit regardless of blanking.
REQ-022 Blanked digit: seg_out = 1111111, dig_sel still asserted for that slot.

Reset
REQ-023 On rst high at a clock edge: prescaler 0, index 0, active and pending registers 0, pending flag 0.
REQ-024 During reset: seg_out = 1111111, dp_out = 1, dig_sel all ones, frame_done = 0.
REQ-025 Reset asserted mid-frame SHALL discard pending data; first cycle after release SHALL drive digit 0 showing 0 (0000001, dig_sel[0] low).

Configuration
REQ-026 Macro SEG7_LZB_EN: when defined, with blank_en = 1 digit i (i>0) SHALL be blanked iff nibbles i..DIGITS-1 of active are all zero.
REQ-027 Without SEG7_LZB_EN, blank_en port SHALL remain present and be ignored; no digit is ever blanked.

Verification
REQ-028 DIGITS=4, CLK_DIV=4, reset then idle -> dig_sel sequence 1110,1101,1011,0111 each held 4 cycles, seg_out 0000001, frame_done every 16 cycles.
REQ-029 load value=16'h1A3F mid-frame -> old digits persist until wrap; next frame shows F,3,A,1 on digits 0..3 with codes 0111000,0000110,0001000,1001111.
REQ-030 Two loads (16'h1111 then 16'h2222) within one frame -> only 2222 displayed after wrap; load on wrap-tick cycle -> new value in the immediately starting frame.
REQ-031 SEG7_LZB_EN defined, blank_en=1, value=16'h0050 -> digits 3,2 blank (1111111), digit 1 = 0100100, digit 0 = 0000001; blank_en=0 -> all four shown.
REQ-032 rst pulsed during digit 2 with pending set -> outputs blank for reset cycle, then digit 0 with active 0; pending value never displayed.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the data/control inputs and the display outputs of the multiplexed
// seven-segment scan driver. clk and rst remain plain ports on the driver.
//
//   value      [4*DIGITS] hex nibbles, value[3:0] is digit 0 (least significant)
//   dp_in      [DIGITS]   decimal point per digit, 1 = lit
//   load       [1]        one-cycle strobe capturing value/dp_in
//   blank_en   [1]        leading-zero blanking request
//   seg_out    [7]        segments {a,b,c,d,e,f,g}, active-low
//   dp_out     [1]        decimal point, active-low
//   dig_sel    [DIGITS]   one-hot-low digit enable
//   frame_done [1]        one-cycle pulse after each frame wrap
//
// master: the producer of display data (e.g. a CPU or testbench)
// slave : the scan driver itself
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                blank_en;
    logic [6:0]          seg_out;
    logic                dp_out;
    logic [DIGITS-1:0]   dig_sel;
    logic                frame_done;

    modport master (
        output value, dp_in, load, blank_en,
        input  seg_out, dp_out, dig_sel, frame_done
    );

    modport slave (
        input  value, dp_in, load, blank_en,
        output seg_out, dp_out, dig_sel, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for a DIGITS-wide common seven-segment display.
// A prescaler divides clk into digit slots of CLK_DIV cycles; each slot drives
// one digit. New data is staged in a pending register and only moved into the
// displayed (active) register at a frame boundary, so a frame never mixes old
// and new digits.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - seg7_scan_driver_if.slave (value, dp_in, load, blank_en in;
//          seg_out, dp_out, dig_sel, frame_done out; all outputs registered)
//
// Parameters:
//   DIGITS  - number of multiplexed digits (1..8)
//   CLK_DIV - clk cycles per digit slot (>= 2)
//
// Optional feature:
//   SEG7_LZB_EN - when defined, blank_en = 1 blanks leading zero digits
//                 (digit 0 is never blanked). When undefined, blank_en is
//                 accepted but has no effect.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_driver_if.slave     bus
);

    localparam int VAL_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(CLK_DIV);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Hex nibble to active-low {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // Scan timing state
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;

    // Data held for display and data waiting for the next frame
    logic [VAL_W-1:0]  act_val_q,  act_val_d;
    logic [DIGITS-1:0] act_dp_q,   act_dp_d;
    logic [VAL_W-1:0]  pend_val_q, pend_val_d;
    logic [DIGITS-1:0] pend_dp_q,  pend_dp_d;
    logic              pend_q,     pend_d;

    // Registered outputs
    logic [6:0]        seg_q, seg_d;
    logic              dp_q,  dp_d;
    logic [DIGITS-1:0] dig_q, dig_d;
    logic              fd_q,  fd_d;

    logic              tick;
    logic              wrap;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic [DIGITS-1:0] blank_vec;

    assign tick = (presc_q == PRE_LAST);
    // The tick that moves the index from the last digit back to digit 0
    assign wrap = tick && (idx_q == IDX_LAST);

`ifdef SEG7_LZB_EN
    // A digit i>0 is a leading zero when it and every more significant
    // nibble are zero; scan from the top down accumulating that condition.
    logic upper_zero;
    always_comb begin
        blank_vec  = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero   = upper_zero & (act_val_q[i*4 +: 4] == 4'h0);
            blank_vec[i] = bus.blank_en & upper_zero;
        end
    end
`else
    // Blanking disabled: blank_en is kept on the interface but ignored.
    logic unused_blank_en;
    assign unused_blank_en = bus.blank_en;
    assign blank_vec       = '0;
`endif

    // Select the nibble, decimal point and blank flag of the current slot
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = act_val_q[i*4 +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = blank_vec[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        presc_d    = presc_q;
        idx_d      = idx_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_d     = pend_q;

        if (tick) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // A load on the wrap tick goes straight to the display because the
        // new frame starts right now; otherwise it waits in pending.
        if (bus.load && wrap) begin
            act_val_d = bus.value;
            act_dp_d  = bus.dp_in;
            pend_d    = 1'b0;
        end else if (bus.load) begin
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp_in;
            pend_d     = 1'b1;
        end else if (wrap && pend_q) begin
            act_val_d = pend_val_q;
            act_dp_d  = pend_dp_q;
            pend_d    = 1'b0;
        end

        // Outputs describe the slot of the current index, one cycle later
        seg_d = cur_blank ? 7'b1111111 : hex_to_seg(cur_nib);
        dp_d  = ~cur_dp;
        dig_d = ~(DIGITS'(1) << idx_q);
        fd_d  = wrap;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_q     <= 1'b0;
            seg_q      <= 7'b1111111;
            dp_q       <= 1'b1;
            dig_q      <= '1;
            fd_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_q     <= pend_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            dig_q      <= dig_d;
            fd_q       <= fd_d;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.dp_out     = dp_q;
    assign bus.dig_sel    = dig_q;
    assign bus.frame_done = fd_q;

endmodule
